// File: rtl/branch_history_predictor.sv
// Branch direction predictor: table of 2-bit saturating counters indexed by
// PC (bimodal) or PC XOR global history (gshare), with non-speculative
// training from EX and resolved/mispredicted branch statistics.
//
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   clk_enable         - gates every state update (reset excepted)
//   IF_opcode/pc/imm   - instruction currently in IF (lookup side)
//   EX_branch/...      - branch resolving in EX (training side)
//   branch_estimation  - predicted direction for the IF instruction (comb)
//   branch_target      - predicted next PC for the IF instruction (comb)
//   IF_pred_index      - table index used for the prediction (comb)
//   branch_count       - resolved branches since reset (registered, saturating)
//   mispredict_count   - mispredicted branches since reset (registered, saturating)
module branch_history_predictor #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_BITS   = 6,
    parameter int unsigned MODE       = 0,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic [6:0]            IF_opcode,
    input  logic [XLEN-1:0]       IF_pc,
    input  logic [XLEN-1:0]       IF_imm,
    input  logic                  EX_branch,
    input  logic                  EX_branch_taken,
    input  logic                  EX_pred_taken,
    input  logic [INDEX_BITS-1:0] EX_pred_index,
    output logic                  branch_estimation,
    output logic [XLEN-1:0]       branch_target,
    output logic [INDEX_BITS-1:0] IF_pred_index,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned TABLE_DEPTH   = 1 << INDEX_BITS;
    localparam int unsigned STAT_W        = 32;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;

    logic [1:0]            pht_q [TABLE_DEPTH];
    logic [GHR_BITS-1:0]   ghr_q;
    logic [STAT_W-1:0]     branch_count_q;
    logic [STAT_W-1:0]     mispredict_count_q;

    logic [INDEX_BITS-1:0] pc_index;
    logic [INDEX_BITS-1:0] lookup_index;
    logic                  counter_taken;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) nxt = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

    // Lookup index; history is zero-extended and always the pre-update value.
    assign pc_index      = IF_pc[INDEX_BITS+1:2];
    assign lookup_index  = (MODE == 1) ? (pc_index ^ INDEX_BITS'(ghr_q)) : pc_index;
    assign counter_taken = pht_q[lookup_index][1];

    // Zero-latency prediction; non-branch instructions produce all zeros.
    always_comb begin
        branch_estimation = 1'b0;
        branch_target     = '0;
        IF_pred_index     = '0;
        if (IF_opcode == OPCODE_BRANCH) begin
            branch_estimation = counter_taken;
            IF_pred_index     = lookup_index;
            branch_target     = counter_taken ? (IF_pc + IF_imm) : (IF_pc + XLEN'(4));
        end
    end

    // Training, history shift and statistics; reset wins over any EX update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                pht_q[INDEX_BITS'(i)] <= INIT_STATE;
            end
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (clk_enable && EX_branch) begin
            pht_q[EX_pred_index] <= sat_update(pht_q[EX_pred_index], EX_branch_taken);
            ghr_q                <= GHR_BITS'({ghr_q, EX_branch_taken});
            if (branch_count_q != '1) begin
                branch_count_q <= branch_count_q + STAT_W'(1);
            end
            if ((EX_pred_taken != EX_branch_taken) && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + STAT_W'(1);
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
